interfaz_uart_alu: RTL and testbench
====================================

Name: interfaz_uart_alu

Overview:
- Sequencer on the operand/result side of the ALU.
- Assembles buf_A, buf_B and buf_Op from bytes delivered by a UART receiver.
- Holds the operands stable while the combinational ALU settles, then captures dato_R.
- Returns the result as bytes to a UART transmitter.
- Sits between the UART RX/TX pair and the ALU in the board-level top.

Parameters:
- nbits, 8, operand/result width; must be a multiple of 8 (8, 16, 24, 32).

Ports:
- clk  input  1  system clock; everything is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- rx_dato  input  8  byte from the UART receiver; valid when rx_done=1.
- rx_done  input  1  one-cycle pulse: rx_dato holds a new byte.
- tx_dato  output  8  byte to the UART transmitter.
- tx_start  output  1  one-cycle pulse requesting transmission of tx_dato.
- tx_done  input  1  one-cycle pulse: transmitter has finished the current byte.
- buf_A  output  nbits  operand A to the ALU (signed).
- buf_B  output  nbits  operand B to the ALU (signed).
- buf_Op  output  6  ALU opcode.
- dato_R  input  nbits  ALU result (combinational from buf_A/buf_B/buf_Op).
- ocupado  output  1  high while the block is in CALC, ENVIAR or ESP_TX.
- perdido  output  1  sticky flag: a byte arrived while the block was busy; cleared only by reset.

Behaviour:
- Definition: NB = nbits/8 bytes per operand and per result.
- Reset (synchronous, reset=1 at a clk edge):
  - Outputs: buf_A=0, buf_B=0, buf_Op=0, tx_dato=0, tx_start=0, ocupado=0, perdido=0.
  - Internal: byte counter=0, shadow registers=0, result register=0; state=ESP_A.
  - Reset has priority over every other event, including mid-operand and mid-transmission. Bytes already sent are not retracted.
- Operand byte order: little-endian; the first byte received goes to bits [7:0].
- State machine:
  - ESP_A: on each rx_done, write rx_dato into byte[cnt] of the shadow A register; cnt++. When the NB-th byte arrives, clear cnt and go to ESP_B. buf_A is not yet updated.
  - ESP_B: same as ESP_A, using the shadow B register. After the NB-th byte go to ESP_OP.
  - ESP_OP:
    - On rx_done, load buf_A<=shadow A, buf_B<=shadow B, buf_Op<=rx_dato[5:0] in the same edge.
    - rx_dato[7:6] are ignored. Undefined opcodes are passed through unchanged; the ALU defines their result.
    - Go to CALC.
  - CALC: exactly one cycle. Capture dato_R into the result register at the end of the cycle; cnt=0; go to ENVIAR.
  - ENVIAR:
    - tx_dato <= result byte[cnt]; tx_start=1 for exactly one cycle; go to ESP_TX.
    - Result is sent little-endian.
  - ESP_TX: on tx_done, cnt++. If cnt reaches NB, clear cnt and go to ESP_A; otherwise go to ENVIAR.
- Output timing:
  - tx_dato is stable from the tx_start cycle until the next ENVIAR.
  - buf_A, buf_B and buf_Op hold their values from ESP_OP completion until the next ESP_OP completion, so they never glitch during operand assembly.
- Latency, last opcode byte to tx_start: rx_done edge → CALC (1 cycle) → ENVIAR (1 cycle). tx_start is asserted on the 3rd clk after the rx_done cycle.
- Boundary conditions:
  - rx_done in CALC, ENVIAR or ESP_TX: byte dropped, perdido<=1, no state change.
  - tx_done outside ESP_TX: ignored.
  - rx_done and tx_done in the same cycle in ESP_TX: the tx_done transition is taken; the byte is dropped and perdido is set.
  - Counter wrap: cnt is ceil(log2(NB+1)) bits wide and never exceeds NB.
  - No arithmetic is performed here; width handling belongs to the ALU. dato_R is captured as raw bits.
- ocupado is registered and consistent with the state one cycle after the state register updates; the bench checks it one cycle late.

Test Plan:
- nbits=8, with the ALU block attached; send 0x05, 0x03, 0x20 (ADD) → buf_A=5, buf_B=3, buf_Op=0x20; tx_start on the 3rd clk after the opcode rx_done with tx_dato=0x08; back in ESP_A after tx_done.
- Send 0x03, 0x05, 0x22 (SUB) → tx_dato=0xFE. Then send 0x80, 0x02, 0x03 (SRA) → tx_dato=0xE0. Then send 0xF0, 0x0F, 0x27 (NOR) → tx_dato=0x00. Back-to-back with no idle cycles between rx_done pulses except the tx handshake.
- After ADD, pulse rx_done with 0x55 while in ESP_TX → byte ignored, perdido=1. The next operation (0x01, 0x01, 0x20) still returns 0x02 and perdido stays 1.
- Send 0x07 (A) then assert reset for 1 cycle → all outputs 0, state ESP_A. The next sequence 0x02, 0x02, 0x20 returns 0x04, proving the partial A was discarded.
- nbits=16: send A=0x34, 0x12; B=0x01, 0x00; Op=0x20 → buf_A=0x1234, buf_B=0x0001; two tx_start pulses with tx_dato 0x35 then 0x12, the second only after the first tx_done.
- Pulse tx_done spuriously in ESP_A and ESP_B, and hold reset across an ENVIAR cycle → no tx_start generated, no state change except the reset forcing ESP_A.

Source files
------------

// File: rtl/interfaz_uart_alu.sv
// UART-to-ALU sequencer: assembles little-endian operands and an opcode from RX bytes,
// captures the combinational ALU result and streams it back out byte by byte.
module interfaz_uart_alu #(
  parameter int nbits = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_dato,
  input  logic             rx_done,
  output logic [7:0]       tx_dato,
  output logic             tx_start,
  input  logic             tx_done,
  output logic [nbits-1:0] buf_A,
  output logic [nbits-1:0] buf_B,
  output logic [5:0]       buf_Op,
  input  logic [nbits-1:0] dato_R,
  output logic             ocupado,
  output logic             perdido
);

  localparam int NB = nbits / 8;
  localparam int CW = $clog2(NB + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);

  localparam logic [2:0] ST_ESP_A   = 3'd0;
  localparam logic [2:0] ST_ESP_B   = 3'd1;
  localparam logic [2:0] ST_ESP_OP  = 3'd2;
  localparam logic [2:0] ST_CALC    = 3'd3;
  localparam logic [2:0] ST_ENVIAR  = 3'd4;
  localparam logic [2:0] ST_ESP_TX  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [nbits-1:0] sh_a_q, sh_a_d;
  logic [nbits-1:0] sh_b_q, sh_b_d;
  logic [nbits-1:0] res_q, res_d;
  logic [nbits-1:0] buf_a_q, buf_a_d;
  logic [nbits-1:0] buf_b_q, buf_b_d;
  logic [5:0]       buf_op_q, buf_op_d;
  logic [7:0]       tx_dato_q, tx_dato_d;
  logic             tx_start_q, tx_start_d;
  logic             ocupado_q, ocupado_d;
  logic             perdido_q, perdido_d;
  logic             busy;

  assign busy = (state_q == ST_CALC) || (state_q == ST_ENVIAR) || (state_q == ST_ESP_TX);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_a_d     = sh_a_q;
    sh_b_d     = sh_b_q;
    res_d      = res_q;
    buf_a_d    = buf_a_q;
    buf_b_d    = buf_b_q;
    buf_op_d   = buf_op_q;
    tx_dato_d  = tx_dato_q;
    tx_start_d = 1'b0;
    ocupado_d  = busy;
    perdido_d  = perdido_q;

    // Any byte arriving while the result path owns the FSM is lost.
    if (rx_done && busy) begin
      perdido_d = 1'b1;
    end

    case (state_q)
      ST_ESP_A: begin
        if (rx_done) begin
          for (int unsigned i = 0; i < NB; i++) begin
            if (cnt_q == i[CW-1:0]) sh_a_d[i*8 +: 8] = rx_dato;
          end
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_ESP_B;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_ESP_B: begin
        if (rx_done) begin
          for (int unsigned i = 0; i < NB; i++) begin
            if (cnt_q == i[CW-1:0]) sh_b_d[i*8 +: 8] = rx_dato;
          end
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_ESP_OP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_ESP_OP: begin
        // Operands reach the ALU together with the opcode so buf_* never show a partial value.
        if (rx_done) begin
          buf_a_d  = sh_a_q;
          buf_b_d  = sh_b_q;
          buf_op_d = rx_dato[5:0];
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        res_d   = dato_R;
        cnt_d   = '0;
        state_d = ST_ENVIAR;
      end
      ST_ENVIAR: begin
        for (int unsigned i = 0; i < NB; i++) begin
          if (cnt_q == i[CW-1:0]) tx_dato_d = res_q[i*8 +: 8];
        end
        tx_start_d = 1'b1;
        state_d    = ST_ESP_TX;
      end
      ST_ESP_TX: begin
        if (tx_done) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_ESP_A;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_ENVIAR;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_ESP_A;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_ESP_A;
      cnt_q      <= '0;
      sh_a_q     <= '0;
      sh_b_q     <= '0;
      res_q      <= '0;
      buf_a_q    <= '0;
      buf_b_q    <= '0;
      buf_op_q   <= '0;
      tx_dato_q  <= '0;
      tx_start_q <= 1'b0;
      ocupado_q  <= 1'b0;
      perdido_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_a_q     <= sh_a_d;
      sh_b_q     <= sh_b_d;
      res_q      <= res_d;
      buf_a_q    <= buf_a_d;
      buf_b_q    <= buf_b_d;
      buf_op_q   <= buf_op_d;
      tx_dato_q  <= tx_dato_d;
      tx_start_q <= tx_start_d;
      ocupado_q  <= ocupado_d;
      perdido_q  <= perdido_d;
    end
  end

  assign buf_A    = buf_a_q;
  assign buf_B    = buf_b_q;
  assign buf_Op   = buf_op_q;
  assign tx_dato  = tx_dato_q;
  assign tx_start = tx_start_q;
  assign ocupado  = ocupado_q;
  assign perdido  = perdido_q;

endmodule

// File: tb/tb_interfaz_uart_alu.sv
// Bench for interfaz_uart_alu: an 8-bit and a 16-bit instance, each driven with a small ALU model.
module tb_interfaz_uart_alu;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  rx_dato8 = '0, rx_dato16 = '0;
  logic        rx_done8 = 1'b0, rx_done16 = 1'b0;
  logic        tx_done8 = 1'b0, tx_done16 = 1'b0;
  logic [7:0]  tx_dato8, tx_dato16;
  logic        tx_start8, tx_start16;
  logic [7:0]  buf_A8, buf_B8, dato_R8;
  logic [15:0] buf_A16, buf_B16, dato_R16;
  logic [5:0]  buf_Op8, buf_Op16;
  logic        ocupado8, ocupado16, perdido8, perdido16;

  interfaz_uart_alu #(.nbits(8)) dut8 (
    .clk(clk), .reset(reset), .rx_dato(rx_dato8), .rx_done(rx_done8),
    .tx_dato(tx_dato8), .tx_start(tx_start8), .tx_done(tx_done8),
    .buf_A(buf_A8), .buf_B(buf_B8), .buf_Op(buf_Op8), .dato_R(dato_R8),
    .ocupado(ocupado8), .perdido(perdido8)
  );

  interfaz_uart_alu #(.nbits(16)) dut16 (
    .clk(clk), .reset(reset), .rx_dato(rx_dato16), .rx_done(rx_done16),
    .tx_dato(tx_dato16), .tx_start(tx_start16), .tx_done(tx_done16),
    .buf_A(buf_A16), .buf_B(buf_B16), .buf_Op(buf_Op16), .dato_R(dato_R16),
    .ocupado(ocupado16), .perdido(perdido16)
  );

  // Reference ALU: ADD 0x20, SUB 0x22, SRA 0x03, NOR 0x27.
  always_comb begin
    dato_R8 = '0;
    case (buf_Op8)
      6'h20: dato_R8 = buf_A8 + buf_B8;
      6'h22: dato_R8 = buf_A8 - buf_B8;
      6'h03: dato_R8 = $signed(buf_A8) >>> buf_B8;
      6'h27: dato_R8 = ~(buf_A8 | buf_B8);
      default: dato_R8 = '0;
    endcase
  end

  always_comb begin
    dato_R16 = '0;
    case (buf_Op16)
      6'h20: dato_R16 = buf_A16 + buf_B16;
      6'h22: dato_R16 = buf_A16 - buf_B16;
      6'h03: dato_R16 = $signed(buf_A16) >>> buf_B16;
      6'h27: dato_R16 = ~(buf_A16 | buf_B16);
      default: dato_R16 = '0;
    endcase
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] res;
  } vec_t;

  vec_t tbl [4];
  int total = 0;
  int bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic send(input bit w, input logic [7:0] b);
    if (w) begin rx_dato16 = b; rx_done16 = 1'b1; end
    else begin rx_dato8 = b; rx_done8 = 1'b1; end
    tick();
    rx_done8  = 1'b0;
    rx_done16 = 1'b0;
  endtask

  task automatic pulse_txd(input bit w);
    if (w) tx_done16 = 1'b1;
    else tx_done8 = 1'b1;
    tick();
    tx_done8  = 1'b0;
    tx_done16 = 1'b0;
  endtask

  function automatic logic get_ts(input bit w);
    return w ? tx_start16 : tx_start8;
  endfunction

  // Counts edges until tx_start is seen; an expired budget shows up as a latency mismatch.
  task automatic wait_ts(input bit w, input string nm, input int exp_lat);
    int k;
    k = 0;
    while (!get_ts(w) && k < 12) begin
      tick();
      k++;
    end
    chk({nm, " tx_start latency"}, k, exp_lat);
  endtask

  task automatic run8(input vec_t v, input string nm, input bit inject, input bit spur);
    if (spur) begin
      pulse_txd(0);
      chk({nm, " spur tx_done ESP_A"}, {31'd0, tx_start8}, 0);
    end
    send(0, v.a);
    if (spur) begin
      pulse_txd(0);
      chk({nm, " spur tx_done ESP_B"}, {31'd0, tx_start8}, 0);
      chk({nm, " busy after spur"}, {31'd0, ocupado8}, 0);
    end
    send(0, v.b);
    send(0, v.op);
    chk({nm, " buf_A"}, {24'd0, buf_A8}, {24'd0, v.a});
    chk({nm, " buf_B"}, {24'd0, buf_B8}, {24'd0, v.b});
    chk({nm, " buf_Op"}, {26'd0, buf_Op8}, {26'd0, v.op[5:0]});
    wait_ts(0, nm, 2);
    chk({nm, " tx_dato"}, {24'd0, tx_dato8}, {24'd0, v.res});
    chk({nm, " ocupado in ESP_TX"}, {31'd0, ocupado8}, 1);
    tick();
    chk({nm, " tx_start one cycle"}, {31'd0, tx_start8}, 0);
    if (inject) begin
      send(0, 8'h55);
      chk({nm, " perdido set"}, {31'd0, perdido8}, 1);
    end
    pulse_txd(0);
    tick();
    chk({nm, " ocupado idle"}, {31'd0, ocupado8}, 0);
    chk({nm, " tx_dato held"}, {24'd0, tx_dato8}, {24'd0, v.res});
  endtask

  initial begin
    int ones;
    tbl[0] = '{a: 8'h05, b: 8'h03, op: 8'h20, res: 8'h08};
    tbl[1] = '{a: 8'h03, b: 8'h05, op: 8'h22, res: 8'hFE};
    tbl[2] = '{a: 8'h80, b: 8'h02, op: 8'h03, res: 8'hE0};
    tbl[3] = '{a: 8'hF0, b: 8'h0F, op: 8'h27, res: 8'h00};

    tick();
    tick();
    reset = 1'b0;
    chk("rst buf_A8", {24'd0, buf_A8}, 0);
    chk("rst buf_B8", {24'd0, buf_B8}, 0);
    chk("rst buf_Op8", {26'd0, buf_Op8}, 0);
    chk("rst tx_dato8", {24'd0, tx_dato8}, 0);
    chk("rst tx_start8", {31'd0, tx_start8}, 0);
    chk("rst ocupado8", {31'd0, ocupado8}, 0);
    chk("rst perdido8", {31'd0, perdido8}, 0);
    chk("rst buf_A16", {16'd0, buf_A16}, 0);
    chk("rst tx_dato16", {24'd0, tx_dato16}, 0);

    for (int i = 0; i < 4; i++) begin
      run8(tbl[i], $sformatf("vec%0d", i), 1'b0, 1'b0);
    end
    chk("no loss after table", {31'd0, perdido8}, 0);

    // Byte arriving in ESP_TX is dropped and the flag is sticky.
    run8(tbl[0], "lost", 1'b1, 1'b0);
    run8('{a: 8'h01, b: 8'h01, op: 8'h20, res: 8'h02}, "after_lost", 1'b0, 1'b0);
    chk("perdido sticky", {31'd0, perdido8}, 1);

    // Reset in the middle of operand A discards the partial byte.
    send(0, 8'h07);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst buf_A8", {24'd0, buf_A8}, 0);
    chk("midrst buf_Op8", {26'd0, buf_Op8}, 0);
    chk("midrst tx_dato8", {24'd0, tx_dato8}, 0);
    chk("midrst perdido8", {31'd0, perdido8}, 0);
    chk("midrst ocupado8", {31'd0, ocupado8}, 0);
    run8('{a: 8'h02, b: 8'h02, op: 8'h20, res: 8'h04}, "post_rst", 1'b0, 1'b0);

    // Spurious tx_done while collecting operands.
    run8('{a: 8'h10, b: 8'h22, op: 8'h20, res: 8'h32}, "spur", 1'b0, 1'b1);

    // Reset held across an ENVIAR cycle suppresses tx_start.
    send(0, 8'h09);
    send(0, 8'h01);
    send(0, 8'h20);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ones = 0;
    for (int i = 0; i < 5; i++) begin
      if (tx_start8) ones++;
      tick();
    end
    chk("rst_envi no tx_start", ones, 0);
    chk("rst_envi ocupado", {31'd0, ocupado8}, 0);
    chk("rst_envi buf_A8", {24'd0, buf_A8}, 0);
    chk("rst_envi tx_dato8", {24'd0, tx_dato8}, 0);
    run8('{a: 8'h06, b: 8'h01, op: 8'h22, res: 8'h05}, "after_rst_envi", 1'b0, 1'b0);

    // 16-bit: little-endian assembly and two-byte result.
    send(1, 8'h34);
    send(1, 8'h12);
    send(1, 8'h01);
    send(1, 8'h00);
    send(1, 8'h20);
    chk("w16 buf_A", {16'd0, buf_A16}, 32'h1234);
    chk("w16 buf_B", {16'd0, buf_B16}, 32'h0001);
    chk("w16 buf_Op", {26'd0, buf_Op16}, 32'h20);
    wait_ts(1, "w16 b0", 2);
    chk("w16 tx_dato b0", {24'd0, tx_dato16}, 32'h35);
    ones = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (tx_start16) ones++;
    end
    chk("w16 waits for tx_done", ones, 0);
    chk("w16 tx_dato b0 held", {24'd0, tx_dato16}, 32'h35);
    pulse_txd(1);
    wait_ts(1, "w16 b1", 1);
    chk("w16 tx_dato b1", {24'd0, tx_dato16}, 32'h12);
    pulse_txd(1);
    tick();
    chk("w16 ocupado idle", {31'd0, ocupado16}, 0);
    chk("w16 perdido clear", {31'd0, perdido16}, 0);

    // rx_done and tx_done together in ESP_TX: transition taken, byte lost.
    send(1, 8'hFF);
    send(1, 8'h00);
    send(1, 8'h01);
    send(1, 8'h00);
    send(1, 8'h20);
    wait_ts(1, "w16c b0", 2);
    chk("w16c tx_dato b0", {24'd0, tx_dato16}, 32'h00);
    rx_dato16 = 8'hAA;
    rx_done16 = 1'b1;
    tx_done16 = 1'b1;
    tick();
    rx_done16 = 1'b0;
    tx_done16 = 1'b0;
    chk("w16c perdido", {31'd0, perdido16}, 1);
    wait_ts(1, "w16c b1", 1);
    chk("w16c tx_dato b1", {24'd0, tx_dato16}, 32'h01);
    pulse_txd(1);
    tick();
    chk("w16c ocupado idle", {31'd0, ocupado16}, 0);
    chk("w16c buf_A kept", {16'd0, buf_A16}, 32'h00FF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
